// File: rtl/dram_lsu_port_if.sv
// Request/response handshake and single-port RAM bus between the CPU memory stage,
// the load/store front end and the data RAM.
interface dram_lsu_port_if #(
   parameter int ADDR_BITS = 20
);
   logic                 req_valid;
   logic                 req_ready;
   logic                 req_wr;
   logic [1:0]           req_size;
   logic                 req_unsigned;
   logic [31:0]          req_addr;
   logic [31:0]          req_wdata;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [31:0]          rsp_rdata;
   logic                 rsp_err;
   logic [ADDR_BITS-1:0] dram_a;
   logic [3:0]           dram_be;
   logic                 dram_we;
   logic [31:0]          dram_d;
   logic [31:0]          dram_spo;

   modport slave (
      input  req_valid, req_wr, req_size, req_unsigned, req_addr, req_wdata,
      input  rsp_ready, dram_spo,
      output req_ready, rsp_valid, rsp_rdata, rsp_err,
      output dram_a, dram_be, dram_we, dram_d
   );

   modport master (
      output req_valid, req_wr, req_size, req_unsigned, req_addr, req_wdata,
      output rsp_ready, dram_spo,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err,
      input  dram_a, dram_be, dram_we, dram_d
   );
endinterface

// File: rtl/dram_lsu_port.sv
// Load/store front end: turns byte/half/word requests into single-port RAM beats.
// Word-crossing accesses are split into two beats (SPLIT_EN=1) or rejected with rsp_err.
module dram_lsu_port #(
   parameter int ADDR_BITS = 20,
   parameter bit SPLIT_EN  = 1'b1
) (
   input  logic           clk,
   input  logic           rst_n,
   dram_lsu_port_if.slave bus
);

   typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

   state_t               state_q, state_d;
   logic                 wr_q, wr_d;
   logic [1:0]           size_q, size_d;
   logic                 uns_q, uns_d;
   logic [ADDR_BITS+1:0] addr_q, addr_d;
   logic [31:0]          wdata_q, wdata_d;
   logic                 cross_q, cross_d;
   logic                 err_q, err_d;
   logic [31:0]          word0_q, word0_d;
   logic [23:0]          word1_q, word1_d;

   logic [2:0]  req_n;
   logic        req_cross, req_bad;
   logic [1:0]  off;
   logic [3:0]  mask;
   logic [31:0] byte_mask;
   logic [7:0]  ext_be;
   logic [63:0] ext_d;
   logic [31:0] raw, ld_data;

   always_comb begin
      case (bus.req_size)
         2'd0:    req_n = 3'd1;
         2'd1:    req_n = 3'd2;
         default: req_n = 3'd4;
      endcase
      req_cross = ({1'b0, bus.req_addr[1:0]} + req_n) > 3'd4;
      req_bad   = (bus.req_size == 2'd3) || (req_cross && !SPLIT_EN);
   end

   // Lane math on a 64-bit two-word window; the upper half feeds the second beat.
   always_comb begin
      off = addr_q[1:0];
      case (size_q)
         2'd0:    begin mask = 4'b0001; byte_mask = 32'h0000_00FF; end
         2'd1:    begin mask = 4'b0011; byte_mask = 32'h0000_FFFF; end
         default: begin mask = 4'b1111; byte_mask = 32'hFFFF_FFFF; end
      endcase
      ext_be = {4'b0000, mask} << off;
      ext_d  = {32'd0, wdata_q & byte_mask} << {off, 3'b000};
      case (off)
         2'd0:    raw = word0_q;
         2'd1:    raw = {word1_q[7:0],  word0_q[31:8]};
         2'd2:    raw = {word1_q[15:0], word0_q[31:16]};
         default: raw = {word1_q[23:0], word0_q[31:24]};
      endcase
      case (size_q)
         2'd0:    ld_data = {{24{raw[7]  & ~uns_q}}, raw[7:0]};
         2'd1:    ld_data = {{16{raw[15] & ~uns_q}}, raw[15:0]};
         default: ld_data = raw;
      endcase
   end

   // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
   always_comb begin
      state_d       = state_q;
      wr_d          = wr_q;
      size_d        = size_q;
      uns_d         = uns_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      cross_d       = cross_q;
      err_d         = err_q;
      word0_d       = word0_q;
      word1_d       = word1_q;
      bus.req_ready = 1'b0;
      bus.rsp_valid = 1'b0;
      bus.rsp_err   = 1'b0;
      bus.rsp_rdata = 32'd0;
      bus.dram_a    = '0;
      bus.dram_be   = 4'd0;
      bus.dram_we   = 1'b0;
      bus.dram_d    = 32'd0;

      case (state_q)
         IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid) begin
               wr_d    = bus.req_wr;
               size_d  = bus.req_size;
               uns_d   = bus.req_unsigned;
               addr_d  = bus.req_addr[ADDR_BITS+1:0];
               wdata_d = bus.req_wdata;
               cross_d = req_cross;
               err_d   = req_bad;
               state_d = req_bad ? RESP : ACC0;
            end
         end
         ACC0: begin
            bus.dram_a  = addr_q[ADDR_BITS+1:2];
            bus.dram_be = ext_be[3:0];
            bus.dram_we = wr_q;
            bus.dram_d  = ext_d[31:0];
            if (!wr_q) word0_d = bus.dram_spo;
            state_d = cross_q ? ACC1 : RESP;
         end
         ACC1: begin
            bus.dram_a  = addr_q[ADDR_BITS+1:2] + ADDR_BITS'(1);
            bus.dram_be = ext_be[7:4];
            bus.dram_we = wr_q;
            bus.dram_d  = ext_d[63:32];
            if (!wr_q) word1_d = bus.dram_spo[23:0];
            state_d = RESP;
         end
         default: begin
            bus.rsp_valid = 1'b1;
            bus.rsp_err   = err_q;
            bus.rsp_rdata = (err_q || wr_q) ? 32'd0 : ld_data;
            if (bus.rsp_ready) state_d = IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only; reset acts asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         wr_q    <= 1'b0;
         size_q  <= 2'd0;
         uns_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= 32'd0;
         cross_q <= 1'b0;
         err_q   <= 1'b0;
         word0_q <= 32'd0;
         word1_q <= 24'd0;
      end else begin
         state_q <= state_d;
         wr_q    <= wr_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         cross_q <= cross_d;
         err_q   <= err_d;
         word0_q <= word0_d;
         word1_q <= word1_d;
      end
   end

endmodule

// File: tb/tb_dram_lsu_port.sv
// Scoreboard bench for dram_lsu_port: instance 0 splits crossing accesses, instance 1 rejects them.
// A shared byte-enabled RAM model answers reads; instance 0 alone writes it.
module tb_dram_lsu_port;

   localparam int AB = 20;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          acc;
   } rsp_t;

   typedef struct {
      logic [AB-1:0] a;
      logic [3:0]    be;
      logic          we;
      logic [31:0]   d;
   } beat_t;

   logic        clk;
   logic        rst_n;
   int          cyc;
   int          total;
   int          bad;
   logic [31:0] mem [0:(1<<AB)-1];

   logic        req_valid   [2];
   logic        req_wr      [2];
   logic [1:0]  req_size    [2];
   logic        req_unsigned[2];
   logic [31:0] req_addr    [2];
   logic [31:0] req_wdata   [2];
   logic        rsp_ready   [2];
   logic        req_ready_s [2];
   logic        rsp_valid_s [2];

   rsp_t  rsp_q [2][$];
   beat_t beat_q[2][$];

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", name, got, exp);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : u
      dram_lsu_port_if #(.ADDR_BITS(AB)) bus ();

      assign bus.req_valid    = req_valid[g];
      assign bus.req_wr       = req_wr[g];
      assign bus.req_size     = req_size[g];
      assign bus.req_unsigned = req_unsigned[g];
      assign bus.req_addr     = req_addr[g];
      assign bus.req_wdata    = req_wdata[g];
      assign bus.rsp_ready    = rsp_ready[g];
      assign bus.dram_spo     = mem[bus.dram_a];
      assign req_ready_s[g]   = bus.req_ready;
      assign rsp_valid_s[g]   = bus.rsp_valid;

      dram_lsu_port #(.ADDR_BITS(AB), .SPLIT_EN(g == 0)) dut (
         .clk   (clk),
         .rst_n (rst_n),
         .bus   (bus)
      );

      rsp_t  cur;
      bit    busy;
      beat_t b;

      always @(negedge clk) begin
         if (!rst_n || !bus.rsp_valid) begin
            busy = 1'b0;
         end else begin
            if (!busy) begin
               if (rsp_q[g].size() == 0) begin
                  check("rsp_unexpected", 64'(bus.rsp_valid), 64'd0);
                  cur.rdata = 32'd0;
                  cur.err   = 1'b0;
               end else begin
                  cur = rsp_q[g].pop_front();
                  check("rsp_latency", 64'(cyc - cur.acc), 64'(cur.lat));
               end
               busy = 1'b1;
            end
            check("rsp_rdata", 64'(bus.rsp_rdata), 64'(cur.rdata));
            check("rsp_err", 64'(bus.rsp_err), 64'(cur.err));
            check("rsp_req_ready_low", 64'(bus.req_ready), 64'd0);
         end
      end

      always @(negedge clk) begin
         if (rst_n) begin
            if (bus.dram_we || bus.dram_be != 4'd0) begin
               if (beat_q[g].size() == 0) begin
                  check("beat_unexpected", 64'({bus.dram_we, bus.dram_be}), 64'd0);
               end else begin
                  b = beat_q[g].pop_front();
                  check("beat_a", 64'(bus.dram_a), 64'(b.a));
                  check("beat_be", 64'(bus.dram_be), 64'(b.be));
                  check("beat_we", 64'(bus.dram_we), 64'(b.we));
                  check("beat_d", 64'(bus.dram_d), 64'(b.d));
               end
            end else begin
               check("idle_bus", {12'd0, bus.dram_a, bus.dram_d}, 64'd0);
            end
         end
      end
   end

   always @(posedge clk) begin
      if (u[0].bus.dram_we)
         for (int i = 0; i < 4; i++)
            if (u[0].bus.dram_be[i]) mem[u[0].bus.dram_a][8*i +: 8] <= u[0].bus.dram_d[8*i +: 8];
   end

   task automatic beat(input int s, input logic [AB-1:0] a, input logic [3:0] be,
                       input logic we, input logic [31:0] d);
      beat_t x;
      x.a = a; x.be = be; x.we = we; x.d = d;
      beat_q[s].push_back(x);
   endtask

   task automatic access(input int s, input logic wr, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err,
                         input int lat, input int hold);
      rsp_t e;
      bit   ok;
      @(posedge clk);
      #2;
      req_valid[s]    = 1'b1;
      req_wr[s]       = wr;
      req_size[s]     = size;
      req_unsigned[s] = uns;
      req_addr[s]     = addr;
      req_wdata[s]    = wdata;
      rsp_ready[s]    = (hold == 0);
      ok = 1'b0;
      for (int k = 0; k < 20 && !ok; k++) begin
         @(negedge clk);
         ok = req_ready_s[s];
      end
      check("accept", 64'(ok), 64'd1);
      if (!ok) begin
         req_valid[s] = 1'b0;
         return;
      end
      e.rdata = exp_rdata;
      e.err   = exp_err;
      e.lat   = lat;
      e.acc   = cyc;
      rsp_q[s].push_back(e);
      @(posedge clk);
      #2 req_valid[s] = 1'b0;
      if (hold > 0) begin
         ok = 1'b0;
         for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            ok = rsp_valid_s[s];
         end
         repeat (hold - 1) @(negedge clk);
         #1 rsp_ready[s] = 1'b1;
      end
      ok = 1'b0;
      for (int k = 0; k < 40 && !ok; k++) begin
         @(negedge clk);
         ok = req_ready_s[s] && (rsp_q[s].size() == 0);
      end
      check("done", 64'(ok), 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=running want=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      total = 0;
      bad   = 0;
      cyc   = 0;
      rst_n = 1'b0;
      for (int s = 0; s < 2; s++) begin
         req_valid[s]    = 1'b0;
         req_wr[s]       = 1'b0;
         req_size[s]     = 2'd0;
         req_unsigned[s] = 1'b0;
         req_addr[s]     = 32'd0;
         req_wdata[s]    = 32'd0;
         rsp_ready[s]    = 1'b1;
      end
      for (int i = 0; i < (1 << AB); i++) mem[i] = 32'd0;
      repeat (2) @(negedge clk);

      check("rst_req_ready0", 64'(u[0].bus.req_ready), 64'd1);
      check("rst_rsp0", {29'd0, u[0].bus.rsp_valid, u[0].bus.rsp_err, u[0].bus.dram_we, u[0].bus.rsp_rdata}, 64'd0);
      check("rst_dram0", {8'd0, u[0].bus.dram_be, u[0].bus.dram_a, u[0].bus.dram_d}, 64'd0);
      check("rst_req_ready1", 64'(u[1].bus.req_ready), 64'd1);
      check("rst_rsp1", {29'd0, u[1].bus.rsp_valid, u[1].bus.rsp_err, u[1].bus.dram_we, u[1].bus.rsp_rdata}, 64'd0);
      check("rst_dram1", {8'd0, u[1].bus.dram_be, u[1].bus.dram_a, u[1].bus.dram_d}, 64'd0);
      @(posedge clk);
      #2 rst_n = 1'b1;

      // aligned word store then load
      beat(0, 20'h4, 4'hF, 1'b1, 32'hDEADBEEF);
      access(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, 0);
      beat(0, 20'h4, 4'hF, 1'b0, 32'h0);
      access(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0);

      // byte lanes and extension
      beat(0, 20'h4, 4'hF, 1'b1, 32'h80FF7F01);
      access(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'h80FF7F01, 32'h0, 1'b0, 2, 0);
      beat(0, 20'h4, 4'b0010, 1'b0, 32'h0);
      access(0, 1'b0, 2'd0, 1'b0, 32'h11, 32'h0, 32'h0000007F, 1'b0, 2, 0);
      beat(0, 20'h4, 4'b1000, 1'b0, 32'h0);
      access(0, 1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0, 2, 0);
      beat(0, 20'h4, 4'b0100, 1'b0, 32'h0);
      access(0, 1'b0, 2'd0, 1'b1, 32'h12, 32'h0, 32'h000000FF, 1'b0, 2, 0);
      beat(0, 20'h4, 4'b1100, 1'b0, 32'h0);
      access(0, 1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 32'hFFFF80FF, 1'b0, 2, 0);

      // sub-word stores: half at lanes 3:2, byte with junk upper data
      beat(0, 20'h4, 4'b1100, 1'b1, 32'hABCD0000);
      access(0, 1'b1, 2'd1, 1'b0, 32'h12, 32'h0000ABCD, 32'h0, 1'b0, 2, 0);
      beat(0, 20'h4, 4'hF, 1'b0, 32'h0);
      access(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hABCD7F01, 1'b0, 2, 0);
      beat(0, 20'h5, 4'b0001, 1'b1, 32'h000000C3);
      access(0, 1'b1, 2'd0, 1'b0, 32'h14, 32'h5A5A5AC3, 32'h0, 1'b0, 2, 0);
      beat(0, 20'h5, 4'b0001, 1'b0, 32'h0);
      access(0, 1'b0, 2'd0, 1'b0, 32'h14, 32'h0, 32'hFFFFFFC3, 1'b0, 2, 0);

      // split store / load across words 5 and 6
      beat(0, 20'h5, 4'b1000, 1'b1, 32'h44000000);
      beat(0, 20'h6, 4'b0111, 1'b1, 32'h00112233);
      access(0, 1'b1, 2'd2, 1'b0, 32'h17, 32'h11223344, 32'h0, 1'b0, 3, 0);
      beat(0, 20'h5, 4'b1000, 1'b0, 32'h0);
      beat(0, 20'h6, 4'b0111, 1'b0, 32'h0);
      access(0, 1'b0, 2'd2, 1'b0, 32'h17, 32'h0, 32'h11223344, 1'b0, 3, 0);

      // split at the top word wraps the second beat to word 0
      beat(0, 20'hFFFFF, 4'b1110, 1'b1, 32'hB2C3D400);
      beat(0, 20'h00000, 4'b0001, 1'b1, 32'h000000A1);
      access(0, 1'b1, 2'd2, 1'b0, 32'h003FFFFD, 32'hA1B2C3D4, 32'h0, 1'b0, 3, 0);
      beat(0, 20'hFFFFF, 4'b1110, 1'b0, 32'h0);
      beat(0, 20'h00000, 4'b0001, 1'b0, 32'h0);
      access(0, 1'b0, 2'd2, 1'b0, 32'h003FFFFD, 32'h0, 32'hA1B2C3D4, 1'b0, 3, 0);
      beat(0, 20'hFFFFF, 4'b1000, 1'b0, 32'h0);
      access(0, 1'b0, 2'd0, 1'b1, 32'h003FFFFF, 32'h0, 32'h000000B2, 1'b0, 2, 0);
      beat(0, 20'hFFFFF, 4'b1000, 1'b0, 32'h0);
      beat(0, 20'h00000, 4'b0001, 1'b0, 32'h0);
      access(0, 1'b0, 2'd1, 1'b0, 32'h003FFFFF, 32'h0, 32'hFFFFA1B2, 1'b0, 3, 0);

      // upper address bits alias
      beat(0, 20'h4, 4'hF, 1'b0, 32'h0);
      access(0, 1'b0, 2'd2, 1'b0, 32'h80000010, 32'h0, 32'hABCD7F01, 1'b0, 2, 0);

      // illegal size: error, no RAM beat
      access(0, 1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, 1, 0);
      access(0, 1'b1, 2'd3, 1'b0, 32'h10, 32'hFFFFFFFF, 32'h0, 1'b1, 1, 0);

      // backpressure: response held 5 cycles; prior illegal store left the word intact
      beat(0, 20'h4, 4'hF, 1'b0, 32'h0);
      access(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hABCD7F01, 1'b0, 2, 5);

      // no-split instance: crossing rejected, in-word boundary accepted
      access(1, 1'b0, 2'd1, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1, 1, 0);
      access(1, 1'b1, 2'd2, 1'b0, 32'h17, 32'h11223344, 32'h0, 1'b1, 1, 0);
      beat(1, 20'h4, 4'hF, 1'b0, 32'h0);
      access(1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hABCD7F01, 1'b0, 2, 0);
      beat(1, 20'h4, 4'b1100, 1'b0, 32'h0);
      access(1, 1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 32'hFFFFABCD, 1'b0, 2, 0);
      beat(1, 20'h4, 4'b1000, 1'b0, 32'h0);
      access(1, 1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 32'hFFFFFFAB, 1'b0, 2, 0);

      // reset pulse during ACC0 of a store
      beat(0, 20'h9, 4'hF, 1'b1, 32'h5555AAAA);
      @(posedge clk);
      #2;
      req_valid[0] = 1'b1;
      req_wr[0]    = 1'b1;
      req_size[0]  = 2'd2;
      req_addr[0]  = 32'h24;
      req_wdata[0] = 32'h5555AAAA;
      @(negedge clk);
      check("rstmid_accept", 64'(req_ready_s[0]), 64'd1);
      @(posedge clk);
      #2 req_valid[0] = 1'b0;
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("rstmid_we_be", 64'({u[0].bus.dram_we, u[0].bus.dram_be}), 64'd0);
      check("rstmid_req_ready", 64'(u[0].bus.req_ready), 64'd1);
      check("rstmid_rsp_valid", 64'(u[0].bus.rsp_valid), 64'd0);
      #1 rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("rstmid_no_commit", 64'(mem[9]), 64'd0);
      check("rstmid_idle_ready", 64'(u[0].bus.req_ready), 64'd1);

      for (int s = 0; s < 2; s++) begin
         check("rsp_q_drained", 64'(rsp_q[s].size()), 64'd0);
         check("beat_q_drained", 64'(beat_q[s].size()), 64'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
